// File: rtl/main_memory_ctrl.sv
// ---------------------------------------------------------------------------
// main_memory_ctrl
//
// Fixed-latency main-memory model sitting behind the cache. It accepts one
// block request at a time over a valid/ready handshake, waits LATENCY cycles,
// then either commits a block write or captures a block read. It presents a
// response until the consumer takes it. Writes are acknowledged with a
// response too, but they leave the read-data register untouched.
//
// Parameters
//   BLOCK_SIZE : bits per memory block and per data port (default 128)
//   ADDR_SIZE  : byte-address width (default 10); the block index is
//                req_addr[ADDR_SIZE-1:4] and the low nibble is ignored
//   LATENCY    : cycles from request acceptance to response (legal 1..15)
//
// Ports
//   clk            : rising-edge clock
//   rst            : synchronous active-high reset (storage is not cleared)
//   req_valid      : request present
//   req_ready      : controller is idle and can accept a request
//   req_row        : 1 = block write, 0 = block read
//   req_addr       : byte address
//   req_write_data : block to store on a write
//   resp_valid     : response available
//   resp_ready     : consumer accepts the response
//   resp_read_data : block returned by the most recent read
//   rd_count       : accepted reads, saturating   (MEM_STATS_EN only)
//   wr_count       : accepted writes, saturating  (MEM_STATS_EN only)
//
// Optional feature macro: MEM_STATS_EN adds the rd_count / wr_count
// statistics counters and ports.
// ---------------------------------------------------------------------------
module main_memory_ctrl #(
  parameter int BLOCK_SIZE = 128,
  parameter int ADDR_SIZE  = 10,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_row,
  input  logic [ADDR_SIZE-1:0]  req_addr,
  input  logic [BLOCK_SIZE-1:0] req_write_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [BLOCK_SIZE-1:0] resp_read_data
`ifdef MEM_STATS_EN
  ,
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count
`endif
);

  localparam int IDX_W = ADDR_SIZE - 4;
  localparam int DEPTH = 1 << IDX_W;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [3:0]              cnt_q;
  logic                    row_q;
  logic [IDX_W-1:0]        idx_q;
  logic [BLOCK_SIZE-1:0]   wdata_q;
  logic [BLOCK_SIZE-1:0]   rdata_q;
  logic                    accept;
  logic                    commit;
  logic                    unused_addr_bits;

  // The array starts out all zero and is deliberately outside the reset
  // domain, so a reset never wipes memory contents.
  logic [BLOCK_SIZE-1:0]   mem [DEPTH] = '{default: '0};

  // The byte-offset nibble has no meaning for whole-block transfers.
  assign unused_addr_bits = ^req_addr[3:0];

  assign req_ready      = (state_q == IDLE);
  assign resp_valid     = (state_q == RESP);
  assign resp_read_data = rdata_q;

  // A request is taken only while idle. The array access happens on the
  // edge where the latency counter has already run down to zero.
  assign accept = (state_q == IDLE) && req_valid;
  assign commit = (state_q == ACCESS) && (cnt_q == 4'd0);

  // Next-state logic: IDLE -> ACCESS on acceptance, ACCESS -> RESP when the
  // counter expires, RESP -> IDLE once the consumer takes the response.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid)  state_d = ACCESS;
      ACCESS:  if (commit)     state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // State register, latency counter and request capture. Request fields are
  // snapshotted on acceptance so later changes on req_* cannot leak into an
  // access already in flight. Read data updates only when a read completes,
  // so a write acknowledgement leaves the previous read data visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      row_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        row_q   <= req_row;
        idx_q   <= req_addr[ADDR_SIZE-1:4];
        wdata_q <= req_write_data;
        cnt_q   <= CNT_LOAD;
      end else if (state_q == ACCESS && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (commit && !row_q) begin
        rdata_q <= mem[idx_q];
      end
    end
  end

  // Block write port. It is gated by reset so a reset landing on the commit
  // edge wins and the write is dropped.
  always_ff @(posedge clk) begin
    if (!rst && commit && row_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

`ifdef MEM_STATS_EN
  // Saturating counters of accepted reads and writes. They count at
  // acceptance, so an access later aborted by reset has still been counted
  // until that reset clears the counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count <= 16'd0;
      wr_count <= 16'd0;
    end else if (accept) begin
      if (req_row) begin
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      end else begin
        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_main_memory_ctrl.sv
// ---------------------------------------------------------------------------
// tb_main_memory_ctrl
//
// Bench for main_memory_ctrl. The main instance uses default parameters
// (LATENCY=4). A second instance with LATENCY=1 has resp_ready tied high.
// Expected responses are queued when a request is accepted and popped when
// the controller presents its response.
// ---------------------------------------------------------------------------
module tb_main_memory_ctrl;

  localparam int BS  = 128;
  localparam int AS  = 10;
  localparam int LAT = 4;

  typedef struct {
    logic          row;
    logic [AS-1:0] addr;
    logic [BS-1:0] wdata;
    logic [BS-1:0] exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_row;
  logic [AS-1:0] req_addr;
  logic [BS-1:0] req_write_data;
  logic          resp_valid;
  logic          resp_ready;
  logic [BS-1:0] resp_read_data;

  logic          l1_valid;
  logic          l1_ready;
  logic          l1_row;
  logic [AS-1:0] l1_addr;
  logic [BS-1:0] l1_wdata;
  logic          l1_resp_valid;
  logic [BS-1:0] l1_rdata;

`ifdef MEM_STATS_EN
  logic [15:0]   rd_count;
  logic [15:0]   wr_count;
  logic [15:0]   l1_rd_count;
  logic [15:0]   l1_wr_count;
`endif

  int total = 0;
  int bad   = 0;
  int exp_rd = 0;
  int exp_wr = 0;
  logic [BS-1:0] sb[$];
  logic [BS-1:0] sb1[$];
  vec_t vecs [9];

  localparam logic [BS-1:0] PAT_A5 = {16{8'hA5}};
  localparam logic [BS-1:0] PAT_P  = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [BS-1:0] PAT_D  = {4{32'hDEADBEEF}};
  localparam logic [BS-1:0] PAT_F  = {4{32'hFFFF0000}};
  localparam logic [BS-1:0] PAT_X  = {8{16'h3C5A}};

  always #5 clk = ~clk;

  main_memory_ctrl #(.BLOCK_SIZE(BS), .ADDR_SIZE(AS), .LATENCY(LAT)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_row        (req_row),
    .req_addr       (req_addr),
    .req_write_data (req_write_data),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_read_data (resp_read_data)
`ifdef MEM_STATS_EN
    ,
    .rd_count       (rd_count),
    .wr_count       (wr_count)
`endif
  );

  main_memory_ctrl #(.BLOCK_SIZE(BS), .ADDR_SIZE(AS), .LATENCY(1)) dut_l1 (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (l1_valid),
    .req_ready      (l1_ready),
    .req_row        (l1_row),
    .req_addr       (l1_addr),
    .req_write_data (l1_wdata),
    .resp_valid     (l1_resp_valid),
    .resp_ready     (1'b1),
    .resp_read_data (l1_rdata)
`ifdef MEM_STATS_EN
    ,
    .rd_count       (l1_rd_count),
    .wr_count       (l1_wr_count)
`endif
  );

  // Compare a data word and record the result.
  task automatic checkOutput(input string name, input logic [BS-1:0] act,
                             input logic [BS-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Compare a single control bit and record the result.
  task automatic checkBit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  // Compare an integer quantity and record the result.
  task automatic checkInt(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Issue one request to the LATENCY=4 instance, scramble req_* after
  // acceptance, measure the latency and check the response. With hold > 0
  // the response is stalled for that many cycles while req_valid toggles
  // with a write to block 7, which must never be accepted.
  task automatic applyStimulus(input logic row, input logic [AS-1:0] addr,
                               input logic [BS-1:0] wdata,
                               input logic [BS-1:0] exp, input int hold);
    int n;
    logic [BS-1:0] want;
    @(negedge clk);
    resp_ready     = (hold == 0);
    req_valid      = 1'b1;
    req_row        = row;
    req_addr       = addr;
    req_write_data = wdata;
    checkBit("ready_idle", req_ready, 1'b1);
    @(posedge clk);
    sb.push_back(exp);
    if (row) exp_wr++; else exp_rd++;
    @(negedge clk);
    req_valid      = 1'b0;
    req_row        = ~row;
    req_addr       = ~addr;
    req_write_data = ~wdata;
    n = 0;
    while (!resp_valid && n < 20) begin
      checkBit("ready_busy", req_ready, 1'b0);
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    checkInt("latency", n, LAT);
    want = sb.pop_front();
    checkOutput("resp_data", resp_read_data, want);
    for (int i = 0; i < hold; i++) begin
      req_valid      = ~req_valid;
      req_row        = 1'b1;
      req_addr       = 10'h070;
      req_write_data = PAT_X;
      @(posedge clk);
      @(negedge clk);
      checkBit("hold_valid", resp_valid, 1'b1);
      checkBit("hold_ready", req_ready, 1'b0);
      checkOutput("hold_data", resp_read_data, want);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkBit("ready_after", req_ready, 1'b1);
    checkBit("valid_after", resp_valid, 1'b0);
  endtask

  // One request on the LATENCY=1 instance: the response must be visible
  // exactly one edge after acceptance.
  task automatic runLat1(input logic row, input logic [AS-1:0] addr,
                         input logic [BS-1:0] wdata, input logic [BS-1:0] exp);
    @(negedge clk);
    l1_valid = 1'b1;
    l1_row   = row;
    l1_addr  = addr;
    l1_wdata = wdata;
    checkBit("l1_ready", l1_ready, 1'b1);
    @(posedge clk);
    sb1.push_back(exp);
    @(negedge clk);
    l1_valid = 1'b0;
    l1_wdata = ~wdata;
    @(posedge clk);
    @(negedge clk);
    checkBit("l1_resp_valid", l1_resp_valid, 1'b1);
    checkOutput("l1_data", l1_rdata, sb1.pop_front());
  endtask

  initial begin
    vecs[0] = '{1'b0, 10'h3C0, '0,     '0};
    vecs[1] = '{1'b1, 10'h12F, PAT_A5, '0};
    vecs[2] = '{1'b0, 10'h120, '0,     PAT_A5};
    vecs[3] = '{1'b1, 10'h3FF, PAT_P,  PAT_A5};
    vecs[4] = '{1'b0, 10'h3F0, '0,     PAT_P};
    vecs[5] = '{1'b0, 10'h12A, '0,     PAT_A5};
    vecs[6] = '{1'b1, 10'h050, PAT_D,  PAT_A5};
    vecs[7] = '{1'b0, 10'h055, '0,     PAT_D};
    vecs[8] = '{1'b0, 10'h000, '0,     '0};

    rst            = 1'b1;
    req_valid      = 1'b0;
    req_row        = 1'b0;
    req_addr       = '0;
    req_write_data = '0;
    resp_ready     = 1'b1;
    l1_valid       = 1'b0;
    l1_row         = 1'b0;
    l1_addr        = '0;
    l1_wdata       = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkBit("rst_ready", req_ready, 1'b1);
    checkBit("rst_valid", resp_valid, 1'b0);
    checkOutput("rst_data", resp_read_data, '0);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].row, vecs[i].addr, vecs[i].wdata, vecs[i].exp, 0);
    end

    // Stalled response while req_valid toggles; then confirm block 7 untouched.
    applyStimulus(1'b0, 10'h3F4, '0, PAT_P, 5);
    applyStimulus(1'b0, 10'h070, '0, '0, 0);

    // Reset two edges after a write to block 5 is accepted.
    @(negedge clk);
    req_valid      = 1'b1;
    req_row        = 1'b1;
    req_addr       = 10'h05C;
    req_write_data = PAT_F;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_rd = 0;
    exp_wr = 0;
    checkBit("abort_ready", req_ready, 1'b1);
    checkBit("abort_valid", resp_valid, 1'b0);
    checkOutput("abort_data", resp_read_data, '0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkBit("abort_no_resp", resp_valid, 1'b0);
    end
    applyStimulus(1'b0, 10'h050, '0, PAT_D, 0);
    applyStimulus(1'b1, 10'h3A0, PAT_X, PAT_D, 0);
    applyStimulus(1'b0, 10'h3A8, '0, PAT_X, 0);

    // Back-to-back write then read of block 63 on the LATENCY=1 instance.
    runLat1(1'b1, 10'h3F0, PAT_X, '0);
    runLat1(1'b0, 10'h3FF, '0, PAT_X);

`ifdef MEM_STATS_EN
    checkInt("rd_count", int'(rd_count), exp_rd);
    checkInt("wr_count", int'(wr_count), exp_wr);
    @(negedge clk);
    dut.rd_count = 16'hFFFF;
    applyStimulus(1'b0, 10'h000, '0, '0, 0);
    checkInt("rd_count_sat", int'(rd_count), 65535);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/main_memory_ctrl.md
MAIN_MEMORY_CTRL -- requirements
Module: main_memory_ctrl

Interface
REQ-001 Parameter BLOCK_SIZE, default 128, SHALL set the bits per memory block and per data port.
REQ-002 Parameter ADDR_SIZE, default 10, SHALL set the byte-address width.
REQ-003 Parameter LATENCY, default 4, legal range 1..15, SHALL set the cycles from request acceptance to response.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 req_valid  input  1  request present.
REQ-008 req_ready  output  1  controller can accept a request.
REQ-009 req_row  input  1  1 = block write, 0 = block read; same convention as the cache out_row.
REQ-010 req_addr  input  ADDR_SIZE  byte address; bits [3:0] are ignored and the block index is [9:4].
REQ-011 req_write_data  input  BLOCK_SIZE  block to store on a write.
REQ-012 resp_valid  output  1  response available.
REQ-013 resp_ready  input  1  consumer accepts the response.
REQ-014 resp_read_data  output  BLOCK_SIZE  block returned by a read.
REQ-015 rd_count  output  16  accepted reads; present only with MEM_STATS_EN.
REQ-016 wr_count  output  16  accepted writes; present only with MEM_STATS_EN.

Function
REQ-017 Storage SHALL be 2^(ADDR_SIZE-4) blocks of BLOCK_SIZE bits, 64x128 by default, and SHALL be zero at time zero.
REQ-018 The FSM SHALL have three states, IDLE, ACCESS and RESP, plus a 4-bit latency counter.
REQ-019 req_ready SHALL be 1 exactly when the state is IDLE.
REQ-020 A request SHALL be accepted on a clock edge where req_valid=1 and req_ready=1.
REQ-021 On acceptance, the block SHALL register req_row, the block index and req_write_data, load the counter with LATENCY-1, and enter ACCESS.
REQ-022 In ACCESS the counter SHALL decrement by one per edge.
REQ-023 On the edge where the counter is 0 in ACCESS, a write SHALL commit the registered data and a read SHALL capture the array into resp_read_data; the state SHALL then go to RESP.
REQ-024 resp_valid SHALL be 1 exactly when the state is RESP, so it first rises LATENCY edges after the accepting edge.
REQ-025 On an edge in RESP with resp_ready=1, the block SHALL return to IDLE, so req_ready is 1 in the following cycle.
REQ-026 While resp_ready=0, resp_valid and resp_read_data SHALL hold stable.
REQ-027 A write SHALL also produce a resp_valid acknowledgement, and resp_read_data SHALL keep its previous value for that write.
REQ-028 Inputs SHALL be ignored outside IDLE, and changes to req_* after acceptance SHALL have no effect.
REQ-029 Read-after-write to the same block SHALL return the newly written data.
REQ-030 Accepted-request throughput SHALL be at most one per LATENCY+1 cycles.

Reset
REQ-031 With rst=1 at an edge, the block SHALL set state=IDLE, req_ready=1 after the edge, resp_valid=0, resp_read_data=0, the counter to 0 and, if present, rd_count=wr_count=0.
REQ-032 Reset SHALL NOT alter the storage array.
REQ-033 Reset in ACCESS before the commit edge SHALL drop the request, leaving a write uncommitted, and no response SHALL follow.
REQ-034 Reset in RESP SHALL drop the pending response.
REQ-035 Reset SHALL take priority over a simultaneous request acceptance or response handshake.

Configuration
REQ-036 Macro MEM_STATS_EN SHALL control the statistics counters.
REQ-037 With MEM_STATS_EN defined, rd_count and wr_count SHALL exist and SHALL each increment on the accepting edge of a read or write respectively.
REQ-038 With MEM_STATS_EN defined, each counter SHALL saturate at 16'hFFFF.
REQ-039 Without MEM_STATS_EN, the ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-040 Reset, then read addr 10'h3C0 -> resp_valid rises 4 edges after acceptance with data 128'h0, and req_ready=0 meanwhile.
REQ-041 Write addr 10'h12F with data 128'hA5A5..A5, then read addr 10'h120 -> the read returns 128'hA5A5..A5, since the low bits are ignored.
REQ-042 Hold resp_ready=0 for 5 cycles in RESP while toggling req_valid -> resp_valid and resp_read_data stay stable, and no new request is accepted.
REQ-043 Assert rst 2 edges after a write to block 5 is accepted -> no response, block 5 keeps its old data, and req_ready=1 after reset.
REQ-044 Run LATENCY=1 with back-to-back write then read of block 63 and resp_ready tied to 1 -> each response arrives 1 edge after acceptance, and the read returns the written data.
REQ-045 With MEM_STATS_EN, perform 3 reads and 2 writes -> rd_count=3 and wr_count=2; preload rd_count to 16'hFFFF -> rd_count stays at 16'hFFFF.
